// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: time-shares one combinational ALU between two requesters.
// The winning request is registered onto the ALU inputs, the result is captured
// and then returned to the owner over a valid/ready response channel.
// Multiply ops (ctrl 4'b0101) keep the ALU inputs stable for MUL_CYCLES cycles.
// Optional macro ALU_ARB_FIXED_PRIO_EN: requester 0 always wins a tie instead
// of round-robin; all timing is otherwise identical.

module alu_share_arbiter #(
    parameter int WIDTH      = 32,
    parameter int CTRL_W     = 4,
    parameter int MUL_CYCLES = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [CTRL_W-1:0] req0_ctrl_i,
    input  logic [WIDTH-1:0]  req0_data1_i,
    input  logic [WIDTH-1:0]  req0_data2_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [CTRL_W-1:0] req1_ctrl_i,
    input  logic [WIDTH-1:0]  req1_data1_i,
    input  logic [WIDTH-1:0]  req1_data2_i,
    output logic              rsp0_valid_o,
    input  logic              rsp0_ready_i,
    output logic              rsp1_valid_o,
    input  logic              rsp1_ready_i,
    output logic [WIDTH-1:0]  rsp_data_o,
    output logic              rsp_zero_o,
    output logic [WIDTH-1:0]  alu_data1_o,
    output logic [WIDTH-1:0]  alu_data2_o,
    output logic [CTRL_W-1:0] alu_ctrl_o,
    input  logic [WIDTH-1:0]  alu_data_i,
    input  logic              alu_zero_i
);

    localparam logic [CTRL_W-1:0] MUL_OP        = CTRL_W'(4'b0101);
    localparam logic [CTRL_W-1:0] FIRST_ILLEGAL = CTRL_W'(4'b1010);
    localparam logic [3:0]        MUL_HOLD      = 4'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              owner;
    logic [3:0]        cnt;
    logic              grant0;
    logic              grant1;
    logic              rsp_taken;
    logic [CTRL_W-1:0] sel_ctrl;
    logic [WIDTH-1:0]  sel_data1;
    logic [WIDTH-1:0]  sel_data2;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic              last_grant;
`endif

    assign rsp_taken = owner ? rsp1_ready_i : rsp0_ready_i;
    assign sel_ctrl  = grant1 ? req1_ctrl_i  : req0_ctrl_i;
    assign sel_data1 = grant1 ? req1_data1_i : req0_data1_i;
    assign sel_data2 = grant1 ? req1_data2_i : req0_data2_i;

    // State register; reset drops any in-flight op.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: accept in IDLE, hold EXEC while counting, leave RESP on handshake.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant0 || grant1) next_state = EXEC;
            EXEC:    if (cnt == 4'd0)      next_state = RESP;
            RESP:    if (rsp_taken)        next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs: grants (hence ready) only in IDLE, response valid only to the owner in RESP.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            grant0 = req0_valid_i;
            grant1 = req1_valid_i && !req0_valid_i;
`else
            if (req0_valid_i && req1_valid_i) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = req0_valid_i;
                grant1 = req1_valid_i;
            end
`endif
        end
        req0_ready_o = grant0;
        req1_ready_o = grant1;
        rsp0_valid_o = (state == RESP) && !owner;
        rsp1_valid_o = (state == RESP) && owner;
    end

    // Datapath: latch the winner onto the ALU, count the multiply hold, capture the result.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            alu_ctrl_o  <= '0;
            alu_data1_o <= '0;
            alu_data2_o <= '0;
            rsp_data_o  <= '0;
            rsp_zero_o  <= 1'b0;
            owner       <= 1'b0;
            cnt         <= 4'd0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant  <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        alu_ctrl_o  <= sel_ctrl;
                        alu_data1_o <= sel_data1;
                        alu_data2_o <= sel_data2;
                        owner       <= grant1;
                        cnt         <= (sel_ctrl == MUL_OP) ? MUL_HOLD : 4'd0;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        last_grant  <= grant1;
`endif
                    end
                end
                EXEC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_data_o <= (alu_ctrl_o >= FIRST_ILLEGAL) ? '0 : alu_data_i;
                        rsp_zero_o <= alu_zero_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed and randomized requests/backpressure against
// a transaction-level model (grant rule, latency timestamps, expected result).

module tb_alu_share_arbiter;

    localparam int WIDTH  = 32;
    localparam int CTRL_W = 4;
    localparam int MUL    = 3;
`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED  = 1'b1;
`else
    localparam bit FIXED  = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    logic              clk_i;
    logic              rst_i;
    logic              req0_valid_i;
    logic              req0_ready_o;
    logic [CTRL_W-1:0] req0_ctrl_i;
    logic [WIDTH-1:0]  req0_data1_i;
    logic [WIDTH-1:0]  req0_data2_i;
    logic              req1_valid_i;
    logic              req1_ready_o;
    logic [CTRL_W-1:0] req1_ctrl_i;
    logic [WIDTH-1:0]  req1_data1_i;
    logic [WIDTH-1:0]  req1_data2_i;
    logic              rsp0_valid_o;
    logic              rsp0_ready_i;
    logic              rsp1_valid_o;
    logic              rsp1_ready_i;
    logic [WIDTH-1:0]  rsp_data_o;
    logic              rsp_zero_o;
    logic [WIDTH-1:0]  alu_data1_o;
    logic [WIDTH-1:0]  alu_data2_o;
    logic [CTRL_W-1:0] alu_ctrl_o;
    logic [WIDTH-1:0]  alu_data_i;
    logic              alu_zero_i;

    int   passed = 0;
    int   total  = 0;
    op_t  q0[$];
    op_t  q1[$];
    op_t  pend0;
    op_t  pend1;
    op_t  cur;
    bit   acc0;
    bit   acc1;
    bit   busy;
    bit   in_exec;
    int   due;
    int   owner_m;
    int   last_w;
    int   cyc;
    logic [31:0] exp_d1;
    logic [31:0] exp_d2;
    logic [3:0]  exp_ctrl;
    logic [31:0] exp_data;
    logic        exp_zero;

    alu_share_arbiter #(
        .WIDTH(WIDTH),
        .CTRL_W(CTRL_W),
        .MUL_CYCLES(MUL)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .req0_valid_i(req0_valid_i),
        .req0_ready_o(req0_ready_o),
        .req0_ctrl_i(req0_ctrl_i),
        .req0_data1_i(req0_data1_i),
        .req0_data2_i(req0_data2_i),
        .req1_valid_i(req1_valid_i),
        .req1_ready_o(req1_ready_o),
        .req1_ctrl_i(req1_ctrl_i),
        .req1_data1_i(req1_data1_i),
        .req1_data2_i(req1_data2_i),
        .rsp0_valid_o(rsp0_valid_o),
        .rsp0_ready_i(rsp0_ready_i),
        .rsp1_valid_o(rsp1_valid_o),
        .rsp1_ready_i(rsp1_ready_i),
        .rsp_data_o(rsp_data_o),
        .rsp_zero_o(rsp_zero_o),
        .alu_data1_o(alu_data1_o),
        .alu_data2_o(alu_data2_o),
        .alu_ctrl_o(alu_ctrl_o),
        .alu_data_i(alu_data_i),
        .alu_zero_i(alu_zero_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Environment ALU; codes 4'hA..4'hF return a nonzero-ish value the arbiter must mask.
    function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'h0:    alu_fn = a & b;
            4'h1:    alu_fn = a | b;
            4'h2:    alu_fn = a ^ b;
            4'h3:    alu_fn = a + b;
            4'h4:    alu_fn = a - b;
            4'h5:    alu_fn = a * b;
            4'h6:    alu_fn = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h7:    alu_fn = a << b[4:0];
            4'h8:    alu_fn = a >> b[4:0];
            4'h9:    alu_fn = ~(a | b);
            default: alu_fn = a + b + 32'd1;
        endcase
    endfunction

    assign alu_data_i = alu_fn(alu_ctrl_o, alu_data1_o, alu_data2_o);
    assign alu_zero_i = (alu_data_i == 32'd0);

    function automatic op_t randOp();
        op_t r;
        r.ctrl = ($urandom_range(0, 3) == 0) ? 4'h5 : 4'($urandom_range(0, 15));
        r.a    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7));
        r.b    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7));
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, obs, exp);
        end else begin
            passed++;
        end
    endtask

    // Drive one cycle of requester and response-side inputs (mode 0 directed, 1 random).
    task automatic applyStimulus(input int mode);
        if (acc0) begin req0_valid_i = 1'b0; acc0 = 1'b0; end
        if (acc1) begin req1_valid_i = 1'b0; acc1 = 1'b0; end
        if (!req0_valid_i) begin
            if (q0.size() > 0) begin pend0 = q0.pop_front(); req0_valid_i = 1'b1; end
            else if (mode == 1 && $urandom_range(0, 9) < 6) begin pend0 = randOp(); req0_valid_i = 1'b1; end
        end
        if (!req1_valid_i) begin
            if (q1.size() > 0) begin pend1 = q1.pop_front(); req1_valid_i = 1'b1; end
            else if (mode == 1 && $urandom_range(0, 9) < 6) begin pend1 = randOp(); req1_valid_i = 1'b1; end
        end
        req0_ctrl_i  = pend0.ctrl;
        req0_data1_i = pend0.a;
        req0_data2_i = pend0.b;
        req1_ctrl_i  = pend1.ctrl;
        req1_data1_i = pend1.a;
        req1_data2_i = pend1.b;
        rsp0_ready_i = (mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 7);
        rsp1_ready_i = (mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 7);
    endtask

    // Compare the DUT against the model for the current cycle, then advance the model.
    task automatic checkStep();
        int win;
        logic [31:0] full;
        win = -1;
        if (busy && cyc == due) begin
            full     = alu_fn(cur.ctrl, cur.a, cur.b);
            exp_data = (cur.ctrl >= 4'hA) ? 32'd0 : full;
            exp_zero = (full == 32'd0);
        end
        if (!busy) begin
            if (req0_valid_i && req1_valid_i) win = FIXED ? 0 : ((last_w == 0) ? 1 : 0);
            else if (req0_valid_i) win = 0;
            else if (req1_valid_i) win = 1;
        end
        in_exec = busy && (cyc < due);
        checkOutput("req0_ready", req0_ready_o, win == 0);
        checkOutput("req1_ready", req1_ready_o, win == 1);
        checkOutput("both_ready", req0_ready_o & req1_ready_o, 0);
        checkOutput("rsp0_valid", rsp0_valid_o, busy && cyc >= due && owner_m == 0);
        checkOutput("rsp1_valid", rsp1_valid_o, busy && cyc >= due && owner_m == 1);
        checkOutput("alu_data1", alu_data1_o, exp_d1);
        checkOutput("alu_data2", alu_data2_o, exp_d2);
        checkOutput("alu_ctrl", alu_ctrl_o, exp_ctrl);
        checkOutput("rsp_data", rsp_data_o, exp_data);
        checkOutput("rsp_zero", rsp_zero_o, exp_zero);
        if (win >= 0) begin
            cur      = (win == 1) ? pend1 : pend0;
            acc0     = (win == 0);
            acc1     = (win == 1);
            busy     = 1'b1;
            owner_m  = win;
            last_w   = win;
            due      = cyc + 1 + ((cur.ctrl == 4'h5) ? MUL : 1);
            exp_d1   = cur.a;
            exp_d2   = cur.b;
            exp_ctrl = cur.ctrl;
        end else if (busy && cyc >= due && ((owner_m == 0) ? rsp0_ready_i : rsp1_ready_i)) begin
            busy = 1'b0;
        end
        cyc++;
    endtask

    task automatic runCycles(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
            applyStimulus(mode);
            @(negedge clk_i);
            checkStep();
        end
    endtask

    // Assert reset in the middle of an EXEC cycle and verify the async clear.
    task automatic resetMidExec();
        int tries;
        tries = 0;
        in_exec = 1'b0;
        while (!in_exec && tries < 100) begin
            runCycles(1, 1);
            tries++;
        end
        checkOutput("reset_wait_exec", in_exec, 1);
        #2 rst_i = 1'b0;
        #1;
        checkOutput("rst_alu_data1", alu_data1_o, 0);
        checkOutput("rst_alu_data2", alu_data2_o, 0);
        checkOutput("rst_alu_ctrl", alu_ctrl_o, 0);
        checkOutput("rst_rsp_data", rsp_data_o, 0);
        checkOutput("rst_rsp_zero", rsp_zero_o, 0);
        checkOutput("rst_rsp0_valid", rsp0_valid_o, 0);
        checkOutput("rst_rsp1_valid", rsp1_valid_o, 0);
        busy     = 1'b0;
        last_w   = 1;
        exp_d1   = 32'd0;
        exp_d2   = 32'd0;
        exp_ctrl = 4'd0;
        exp_data = 32'd0;
        exp_zero = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        applyStimulus(1);
        @(negedge clk_i);
        checkStep();
    endtask

    initial begin
        rst_i        = 1'b0;
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        pend0        = '0;
        pend1        = '0;
        acc0         = 1'b0;
        acc1         = 1'b0;
        rsp0_ready_i = 1'b0;
        rsp1_ready_i = 1'b0;
        req0_ctrl_i  = '0;
        req0_data1_i = '0;
        req0_data2_i = '0;
        req1_ctrl_i  = '0;
        req1_data1_i = '0;
        req1_data2_i = '0;
        busy         = 1'b0;
        in_exec      = 1'b0;
        due          = 0;
        owner_m      = 0;
        last_w       = 1;
        cyc          = 0;
        cur          = '0;
        exp_d1       = 32'd0;
        exp_d2       = 32'd0;
        exp_ctrl     = 4'd0;
        exp_data     = 32'd0;
        exp_zero     = 1'b0;

        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        checkStep();
        rst_i = 1'b1;

        $display("[TB] directed: single add 5+7");
        q0.push_back('{ctrl: 4'h3, a: 32'd5, b: 32'd7});
        runCycles(6, 0);

        $display("[TB] directed: both requesters contending");
        for (int i = 0; i < 4; i++) begin
            q0.push_back('{ctrl: 4'h4, a: 32'd9, b: 32'd9});
            q1.push_back('{ctrl: 4'h0, a: 32'hF0, b: 32'h3C});
        end
        runCycles(30, 0);

        $display("[TB] directed: multiply hold");
        q1.push_back('{ctrl: 4'h5, a: 32'hFFFF_FFFD, b: 32'd4});
        runCycles(12, 0);

        $display("[TB] random traffic with backpressure");
        runCycles(1500, 1);

        $display("[TB] reset during EXEC");
        resetMidExec();
        runCycles(300, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU (32-bit operands, 4-bit control, data result + Zero flag) between two requesters, e.g. the EX stage and a branch/address helper.
- Registers the winning request, drives the ALU from those registers, captures the result, and returns it to the owner over a valid/ready response channel.
- Round-robin arbitration; a multi-cycle hold is applied to multiply ops (ctrl 4'b0101).

Parameters:
- WIDTH, 32, operand/result width.
- CTRL_W, 4, ALU control width.
- MUL_CYCLES, 1, cycles the EXEC state holds for ctrl 4'b0101 (legal range 1..15).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- req0_valid_i  in  1  requester 0 op valid.
- req0_ready_o  out  1  requester 0 accepted this cycle.
- req0_ctrl_i  in  CTRL_W  requester 0 ALU op.
- req0_data1_i  in  WIDTH  requester 0 operand 1.
- req0_data2_i  in  WIDTH  requester 0 operand 2.
- req1_valid_i, req1_ready_o, req1_ctrl_i, req1_data1_i, req1_data2_i  same as above, requester 1.
- rsp0_valid_o  out  1  result for requester 0 valid.
- rsp0_ready_i  in  1  requester 0 takes result.
- rsp1_valid_o, rsp1_ready_i  same as above, requester 1.
- rsp_data_o  out  WIDTH  result (shared; qualify with rspN_valid_o).
- rsp_zero_o  out  1  captured Zero flag.
- alu_data1_o  out  WIDTH  to ALU operand 1.
- alu_data2_o  out  WIDTH  to ALU operand 2.
- alu_ctrl_o  out  CTRL_W  to ALU control.
- alu_data_i  in  WIDTH  ALU result.
- alu_zero_i  in  1  ALU Zero.

Behaviour:
- Reset (rst_i low, any time, async):
  - state=IDLE; all registered outputs 0 (alu_*_o, rsp_data_o, rsp_zero_o, rsp*_valid_o).
  - last_grant=1, so req0 wins the first tie.
  - Any in-flight op is discarded; no response is issued.
- FSM states:
  - IDLE: if any reqN_valid_i, select a winner and assert its reqN_ready_o combinationally, same cycle. On the edge, latch ctrl/data1/data2 into the alu_*_o registers, set owner, last_grant=owner, cnt=(ctrl==4'b0101)?MUL_CYCLES-1:0, go EXEC.
  - EXEC: alu_*_o stable. If cnt!=0, decrement and stay. Else capture alu_data_i->rsp_data_o and alu_zero_i->rsp_zero_o, go RESP.
  - RESP: rsp<owner>_valid_o=1. On rsp<owner>_ready_i=1, clear valid and go IDLE. rsp_data_o/rsp_zero_o hold until the next capture.
- Ready rules:
  - reqN_ready_o is high only in IDLE, for the winner only, and only when reqN_valid_i is high.
  - Never both ready signals high in the same cycle.
- Arbitration (default):
  - Only one valid: that requester wins.
  - Both valid: winner = !last_grant.
- Requester contract: hold valid, ctrl and operands stable until ready. The arbiter samples them only on the accept edge.
- Latency: accept edge T; result captured at edge T+MUL_CYCLES for mul, T+1 otherwise; rsp_valid high the following cycle.
  - Minimum issue interval: 3 cycles (non-mul, rsp_ready already high).
- Response backpressure: while rsp_ready is low, stay in RESP. rsp_valid and rsp_data stay stable; no new accept.
- Illegal ctrl (4'b1010..4'b1111): forwarded unchanged to the ALU; rsp_data_o captured as 0; rsp_zero_o captured from alu_zero_i.
- Arithmetic: none internal; the width of every datapath is WIDTH. cnt is 4 bits.
- rspN_ready_i is ignored when rspN_valid_o is low.

Optional Feature:
- ALU_ARB_FIXED_PRIO_EN
  - Defined: fixed priority, req0 always wins when both valid; last_grant is unused (may be removed).
  - Undefined: round-robin as above.
  - All other timing is identical in both cases.

Test Plan:
- req0 valid, ctrl 0011, data 5/7, rsp0_ready=1 -> req0_ready at T; alu_*_o = 5/7/0011 from T+1; rsp0_valid at T+2 with rsp_data_o=12, rsp_zero_o=0; IDLE at T+3.
- req0 and req1 held valid from reset, ops 0100 (9-9) and 0000 (0xF0 & 0x3C) -> grants in order req0, req1, req0, ...; rsp0 data 0 with zero 1; rsp1 data 0x30 with zero 0; never both ready.
- MUL_CYCLES=3, req1 ctrl 0101, data -3 and 4 -> rsp1_valid 4 cycles after accept; rsp_data_o=0xFFFFFFF4.
- rsp0_ready held low 3 cycles in RESP while req1 is valid -> rsp0_valid and data stable; req1_ready stays 0; req1 accepted the cycle after IDLE is re-entered.
- rst_i pulsed low mid-EXEC -> all outputs 0 immediately; no rsp_valid afterwards; next request is served normally.
- With ALU_ARB_FIXED_PRIO_EN, both requesters continuously valid -> req0 granted every time; req1 starved.
